// File: rtl/timer_counter.sv
// Timer counting engine: power-of-two prescaler driving a 64-bit up-counter,
// with delayed TDR0/TDR1 loads and a clear on the falling edge of the enable.
module timer_counter #(
   parameter int unsigned MAX_DIV = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        timer_en,
   input  logic        div_en,
   input  logic [3:0]  div_val,
   input  logic        halt,
   input  logic [31:0] tdr0,
   input  logic [31:0] tdr1,
   input  logic        tdr0_wr_sel,
   input  logic        tdr1_wr_sel,
   output logic [31:0] count_0,
   output logic [31:0] count_1
);

   logic [63:0] cnt_q, cnt_d;
   logic [7:0]  pre_q, pre_d;
   logic        en_q, ld0_q, ld1_q;
   logic [3:0]  dv;
   logic [7:0]  lim;
   logic        tick;
   logic        dis_edge;

   always_comb begin
      dv = div_val;
      if ({28'd0, div_val} > MAX_DIV) begin
         dv = 4'(MAX_DIV);
      end
      lim = 8'((9'd1 << dv) - 9'd1);
   end

   always_comb begin
      tick = 1'b0;
      if (timer_en && !halt) begin
         tick = div_en ? (pre_q == lim) : 1'b1;
      end
   end

   assign dis_edge = en_q && !timer_en;

   always_comb begin
      pre_d = pre_q;
      if (!timer_en || !div_en) begin
         pre_d = 8'd0;
      end else if (!halt) begin
         // >= rather than == so a shrinking div_val cannot strand pre above lim
         pre_d = (pre_q >= lim) ? 8'd0 : pre_q + 8'd1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (dis_edge) begin
         cnt_d = 64'd0;
      end else if (ld0_q || ld1_q) begin
         if (ld0_q) cnt_d[31:0]  = tdr0;
         if (ld1_q) cnt_d[63:32] = tdr1;
      end else if (tick) begin
         cnt_d = cnt_q + 64'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 64'd0;
         pre_q <= 8'd0;
         en_q  <= 1'b0;
         ld0_q <= 1'b0;
         ld1_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pre_q <= pre_d;
         en_q  <= timer_en;
         // TDRx holds the written value only one cycle after the write strobe
         ld0_q <= tdr0_wr_sel;
         ld1_q <= tdr1_wr_sel;
      end
   end

   assign count_0 = cnt_q[31:0];
   assign count_1 = cnt_q[63:32];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: per-cycle vector table plus hand-written
// sequences for prescale periods, clamping, halt, disable clear and async reset.
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        rst;
   logic        timer_en, div_en, halt, tdr0_wr_sel, tdr1_wr_sel;
   logic [3:0]  div_val;
   logic [31:0] tdr0, tdr1;
   logic [31:0] count_0, count_1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   timer_counter #(.MAX_DIV(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .timer_en   (timer_en),
      .div_en     (div_en),
      .div_val    (div_val),
      .halt       (halt),
      .tdr0       (tdr0),
      .tdr1       (tdr1),
      .tdr0_wr_sel(tdr0_wr_sel),
      .tdr1_wr_sel(tdr1_wr_sel),
      .count_0    (count_0),
      .count_1    (count_1)
   );

   typedef struct {
      logic        en;
      logic        den;
      logic [3:0]  dv;
      logic        hlt;
      logic        w0;
      logic        w1;
      logic [31:0] t0;
      logic [31:0] t1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   localparam int NVEC = 29;
   vec_t tbl [NVEC];

   function automatic vec_t mk(input logic en, input logic den, input logic [3:0] dv,
                               input logic hlt, input logic w0, input logic w1,
                               input logic [31:0] t0, input logic [31:0] t1,
                               input logic [31:0] e0, input logic [31:0] e1);
      vec_t v;
      v.en = en; v.den = den; v.dv = dv; v.hlt = hlt; v.w0 = w0; v.w1 = w1;
      v.t0 = t0; v.t1 = t1; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] exp);
      logic [63:0] act;
      act = {count_1, count_0};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0; halt = 1'b0;
      tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0; tdr0 = 32'd0; tdr1 = 32'd0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int eff;
      tbl[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'd1,        32'h0);
      tbl[1]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'd2,        32'h0);
      tbl[2]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'd3,        32'h0);
      tbl[3]  = mk(1, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'd4,        32'h0);
      tbl[4]  = mk(1, 0, 0, 0, 0, 0, 32'h12345678, 32'h0,        32'h12345678, 32'h0);
      tbl[5]  = mk(1, 0, 0, 0, 0, 0, 32'h12345678, 32'h0,        32'h12345679, 32'h0);
      tbl[6]  = mk(1, 0, 0, 0, 0, 1, 32'h12345678, 32'h0,        32'h1234567A, 32'h0);
      tbl[7]  = mk(1, 0, 0, 0, 0, 0, 32'h12345678, 32'hAAAA0001, 32'h1234567A, 32'hAAAA0001);
      tbl[8]  = mk(1, 0, 0, 0, 0, 0, 32'h12345678, 32'hAAAA0001, 32'h1234567B, 32'hAAAA0001);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 32'h12345678, 32'hAAAA0001, 32'h0,        32'h0);
      tbl[10] = mk(0, 0, 0, 0, 1, 0, 32'h12345678, 32'hAAAA0001, 32'h0,        32'h0);
      tbl[11] = mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'hAAAA0001, 32'hFFFFFFFE, 32'h0);
      tbl[12] = mk(0, 0, 0, 0, 0, 1, 32'hFFFFFFFE, 32'hAAAA0001, 32'hFFFFFFFE, 32'h0);
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFE, 32'h0);
      tbl[14] = mk(1, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFF, 32'h0);
      tbl[15] = mk(1, 0, 0, 0, 0, 0, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h1);
      tbl[16] = mk(0, 0, 0, 0, 1, 1, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h0);
      tbl[17] = mk(0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tbl[18] = mk(1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0);
      tbl[19] = mk(1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0);
      tbl[20] = mk(1, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h1,        32'h0);
      tbl[21] = mk(1, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h1,        32'h0);
      tbl[22] = mk(1, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h1,        32'h0);
      tbl[23] = mk(1, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h2,        32'h0);
      tbl[24] = mk(1, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h2,        32'h0);
      tbl[25] = mk(1, 1, 2, 1, 0, 0, 32'h0,        32'h0,        32'h2,        32'h0);
      tbl[26] = mk(1, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h2,        32'h0);
      tbl[27] = mk(1, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h2,        32'h0);
      tbl[28] = mk(1, 1, 2, 0, 0, 0, 32'h0,        32'h0,        32'h3,        32'h0);

      rst = 1'b1;
      timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0; halt = 1'b0;
      tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0; tdr0 = 32'd0; tdr1 = 32'd0;
      step();
      step();
      chk("reset_held", 64'd0);
      rst = 1'b0;
      step();
      chk("reset_idle", 64'd0);

      for (int i = 0; i < NVEC; i++) begin
         timer_en = tbl[i].en; div_en = tbl[i].den; div_val = tbl[i].dv;
         halt = tbl[i].hlt; tdr0_wr_sel = tbl[i].w0; tdr1_wr_sel = tbl[i].w1;
         tdr0 = tbl[i].t0; tdr1 = tbl[i].t1;
         step();
         chk($sformatf("vec%0d", i), {tbl[i].e1, tbl[i].e0});
      end

      do_reset();
      timer_en = 1'b1;
      repeat (10) step();
      chk("undivided_10", 64'd10);

      do_reset();
      timer_en = 1'b1; div_en = 1'b1; div_val = 4'd2;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk($sformatf("div4_edge%0d", k), 64'(k / 4));
      end

      do_reset();
      timer_en = 1'b1; div_en = 1'b1; div_val = 4'd15;
      for (int k = 1; k <= 512; k++) begin
         step();
         if (k == 255 || k == 256 || k == 511 || k == 512)
            chk($sformatf("clamp_edge%0d", k), 64'(k / 256));
      end

      do_reset();
      timer_en = 1'b1; div_en = 1'b1; div_val = 4'd1;
      for (int k = 1; k <= 16; k++) begin
         halt = (k >= 4 && k <= 10);
         step();
         eff = (k <= 3) ? k : ((k <= 10) ? 3 : k - 7);
         chk($sformatf("halt_edge%0d", k), 64'(eff / 2));
      end
      halt = 1'b0;
      #2 rst = 1'b1;
      #1 chk("rst_async", 64'd0);
      #1 rst = 1'b0;
      step();
      chk("post_rst_edge1", 64'd0);
      step();
      chk("post_rst_edge2", 64'd1);

      do_reset();
      timer_en = 1'b1;
      repeat (80) step();
      chk("run_to_0x50", 64'h50);
      timer_en = 1'b0;
      step();
      chk("disable_clear", 64'd0);
      step();
      chk("disabled_hold", 64'd0);
      timer_en = 1'b1;
      step();
      chk("reenable_1", 64'd1);
      step();
      chk("reenable_2", 64'd2);

      do_reset();
      timer_en = 1'b1; div_en = 1'b1; div_val = 4'd1;
      tdr0_wr_sel = 1'b1;
      step();
      tdr0_wr_sel = 1'b0; tdr0 = 32'h100;
      step();
      chk("load_vs_prescaled_tick", 64'h100);
      step();
      chk("load_then_prescale", 64'h100);
      step();
      chk("load_then_tick", 64'h101);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/timer_counter.md
# timer_counter

Counting engine of the timer: a programmable prescaler plus a 64-bit up-counter, exposed as two 32-bit halves. It sits directly downstream of the timer register file. It consumes the enable, divider, halt and data-register load controls, and returns `count_0`/`count_1`; the register file mirrors these into TDR0/TDR1 and compares them against TCMP0/TCMP1.

## Interface
Parameters:
- `MAX_DIV`, 8, largest honoured `div_val`; any larger value is clamped to `MAX_DIV`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `timer_en`  in  1  counter enable (TCR[0]).
- `div_en`  in  1  prescaler enable (TCR[1]).
- `div_val`  in  4  prescaler exponent; the tick period is 2^div_val cycles.
- `halt`  in  1  debug halt acknowledge; freezes all counting.
- `tdr0`  in  32  TDR0 register value, used as the low-word load source.
- `tdr1`  in  32  TDR1 register value, used as the high-word load source.
- `tdr0_wr_sel`  in  1  APB write to TDR0 in progress this cycle.
- `tdr1_wr_sel`  in  1  APB write to TDR1 in progress this cycle.
- `count_0`  out  32  counter bits [31:0].
- `count_1`  out  32  counter bits [63:32].

## Operation
- Internal state:
  - `cnt[63:0]`: `count_0` = `cnt[31:0]`, `count_1` = `cnt[63:32]`.
  - `pre[7:0]`: prescaler.
  - `en_d`: `timer_en` delayed by one cycle.
  - `ld0_d`, `ld1_d`: `tdr0_wr_sel` and `tdr1_wr_sel` delayed by one cycle.
- Effective exponent: `dv = min(div_val, MAX_DIV)`. Limit: `lim = 2^dv - 1`, computed 8 bits wide.
- Tick generation (`tick`, combinational):
  - `timer_en=0` or `halt=1`: `tick=0`.
  - `div_en=0`: `tick=1` every cycle.
  - `div_en=1`: `tick=1` when `pre==lim`.
- Prescaler update:
  - Cleared to 0 when `timer_en=0` or `div_en=0`.
  - Held when `halt=1`.
  - Otherwise it is 0 if `pre>=lim`, else `pre+1`. The `>=` recovers if `div_val` shrinks mid-count.
- Counter update, highest priority first:
  1. `rst`: `cnt=0`, `pre=0`, `en_d=0`, `ld0_d=0`, `ld1_d=0`.
  2. Disable edge (`en_d=1 & timer_en=0`): `cnt=0`, `pre=0`. This matches the TDR clear in the register file.
  3. Load (`ld0_d | ld1_d`):
     - If `ld0_d=1`, `cnt[31:0] <= tdr0`.
     - If `ld1_d=1`, `cnt[63:32] <= tdr1`.
     - A half that is not being loaded holds its value.
     - No increment happens in a load cycle, even if `tick=1`. The prescaler still advances per its normal rule.
  4. `tick=1`: `cnt <= cnt + 1` as one 64-bit add. The low word carries into the high word in the same cycle. `0xFFFF_FFFF_FFFF_FFFF` wraps to 0 with no flag.
  5. Otherwise `cnt` holds.
- Load is delayed one cycle because the register file latches `wdata` into TDRx on the write edge. `tdrX` carries the written value only in the following cycle.
- `halt` has no effect on loads or on the disable clear.
- `timer_en=0` with no falling edge: `cnt` holds. Loads are still accepted, so software can preset the counter while it is stopped.

## Timing
- Reset values: `count_0=0x0000_0000`, `count_1=0x0000_0000`. All internal state is 0.
- Outputs come straight from registers; there is no combinational path from inputs to outputs.
- Enable latency: with `timer_en` high from edge N and `div_en=0`, `cnt` becomes 1 after edge N+1.
- Prescaled rate: with `div_en=1`, `cnt` increments once every 2^dv cycles. The first increment occurs 2^dv cycles after enable.
- Load latency: for an APB write with `tdr0_wr_sel=1` at edge N, `count_0 = tdr0` after edge N+2. Counting resumes from that value at edge N+3.
- Disable clear: when `timer_en` falls at edge N, `cnt=0` after edge N+1.
- Halt:
  - Rising `halt` stops both the prescaler and the counter in the same cycle.
  - Falling `halt` resumes from the exact frozen `pre` value. No ticks are lost or added.
- `rst` assertion takes effect immediately and asynchronously, including during a load or a prescale period. Deassertion is expected to be synchronous to `clk`.

## Test plan
- Reset, then `timer_en=1`, `div_en=0` for 10 cycles -> `count_0=10`, `count_1=0`.
- `div_en=1`, `div_val=2`, enable for 16 cycles -> `count_0=4`; increments land every 4th cycle. Repeat with `div_val=15` -> period 256 (clamped to 8).
- Stopped counter:
  - Preload `tdr0=0xFFFF_FFFE` via write, then `tdr1=0x0000_0000`, then enable with `div_en=0`.
  - After 2 ticks -> `count_0=0`, `count_1=1`.
  - Preload both halves to all-ones, 1 tick -> both halves 0.
- Running with `div_val=1`:
  - Assert `halt` for 7 cycles mid-period -> `count_0` and `pre` frozen.
  - After release -> the next increment arrives exactly where it would have without the halt, shifted by 7 cycles.
- Running at `count_0=0x50`, drop `timer_en` -> `count_0=0` one cycle later. Re-enable -> counts from 0.
- Collision cases:
  - `tdr0` load coincides with a tick -> `count_0` equals the loaded value, not value+1.
  - `rst` pulsed mid-prescale -> outputs 0 immediately.
